// File: rtl/instr_fetch_stage.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Instruction fetch stage that sits directly after the program counter.
// It contains a 64-entry instruction memory, which is loaded through a
// write-only download port, and an IF/ID output register. That register has
// flush and stall control and feeds the decoder.
// It also keeps a wrapping 8-bit count of accepted fetches for debug.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int             IW       = 16,
    parameter int             AW       = 6,
    parameter int             DEPTH    = 64,
    parameter logic [IW-1:0]  NOP_WORD = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] PC_ADDR,
    input  logic          LOAD_EN,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [IW-1:0] LOAD_DATA,
    input  logic          STALL,
    input  logic          FLUSH,
    output logic [IW-1:0] INSTR,
    output logic [AW-1:0] INSTR_ADDR,
    output logic          INSTR_VALID,
    output logic [7:0]    FETCH_CNT
);

    // Instruction storage and the IF/ID register.
    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_instr_addr;
    logic          r_instr_valid;
    logic [7:0]    r_fetch_cnt;

    logic          w_bypass;
    logic [IW-1:0] w_rd_data;

    // Read path. A download that hits the address being fetched forwards its
    // data, so the stage never returns the stale word.
    always_comb begin
        // NOTE: give every always_comb output a default before any branch, so that no latch is inferred.
        w_bypass  = LOAD_EN && (LOAD_ADDR == PC_ADDR);
        w_rd_data = r_mem[PC_ADDR];
        if (w_bypass) begin
            w_rd_data = LOAD_DATA;
        end
    end

    // Program download port. It ignores stall and flush.
    always_ff @(posedge CLK) begin
        // NOTE: the memory array has no reset on purpose. The program must survive a reset, and leaving out the reset lets the array map onto RAM.
        if (LOAD_EN) begin
            r_mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    // IF/ID register. Priority is flush, then stall, then a normal fetch.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples the values from before the edge.
        if (!RST) begin
            r_instr       <= NOP_WORD;
            r_instr_addr  <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_cnt   <= 8'd0;
        end else if (FLUSH) begin
            r_instr       <= NOP_WORD;
            r_instr_addr  <= PC_ADDR;
            r_instr_valid <= 1'b0;
        end else if (!STALL) begin
            r_instr       <= w_rd_data;
            r_instr_addr  <= PC_ADDR;
            r_instr_valid <= 1'b1;
            r_fetch_cnt   <= r_fetch_cnt + 8'd1;
        end
    end

    // Every output comes straight from a register, so no input reaches an output combinationally.
    assign INSTR       = r_instr;
    assign INSTR_ADDR  = r_instr_addr;
    assign INSTR_VALID = r_instr_valid;
    assign FETCH_CNT   = r_fetch_cnt;

endmodule

// File: tb/tb_instr_fetch_stage.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Testbench for instr_fetch_stage. The driver drives stimulus and pushes the
// response that the reference model expects into a queue. A separate monitor
// pops that queue and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        logic [15:0] instr;
        logic [5:0]  addr;
        logic        valid;
        logic [7:0]  cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [5:0]  PC_ADDR = '0;
    logic        LOAD_EN = 1'b0;
    logic [5:0]  LOAD_ADDR = '0;
    logic [15:0] LOAD_DATA = '0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic [15:0] INSTR;
    logic [5:0]  INSTR_ADDR;
    logic        INSTR_VALID;
    logic [7:0]  FETCH_CNT;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] m_mem [64];
    exp_t        m_out;
    int          m_cnt;
    exp_t        sb_q [$];

    instr_fetch_stage #(
        .IW(16), .AW(6), .DEPTH(64), .NOP_WORD(NOP)
    ) dut (
        .CLK(CLK), .RST(RST), .PC_ADDR(PC_ADDR), .LOAD_EN(LOAD_EN),
        .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .STALL(STALL),
        .FLUSH(FLUSH), .INSTR(INSTR), .INSTR_ADDR(INSTR_ADDR),
        .INSTR_VALID(INSTR_VALID), .FETCH_CNT(FETCH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor. The outputs are sampled on the falling edge, well away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("instr", 32'(INSTR), 32'(e.instr));
                check("instr_addr", 32'(INSTR_ADDR), 32'(e.addr));
                check("instr_valid", 32'(INSTR_VALID), 32'(e.valid));
                check("fetch_cnt", 32'(FETCH_CNT), 32'(e.cnt));
            end
        end
    end

    function automatic void model_reset();
        m_out.instr = NOP;
        m_out.addr  = '0;
        m_out.valid = 1'b0;
        m_cnt       = 0;
        m_out.cnt   = 8'd0;
    endfunction

    // Run one clock cycle. The task is entered just after a falling edge
    // and returns just after the next falling edge.
    task automatic cycle(input logic rst, input logic [5:0] pc, input logic ld,
                         input logic [5:0] la, input logic [15:0] ld_d,
                         input logic st, input logic fl);
        RST = rst; PC_ADDR = pc; LOAD_EN = ld; LOAD_ADDR = la;
        LOAD_DATA = ld_d; STALL = st; FLUSH = fl;
        @(posedge CLK);
        if (!rst) begin
            model_reset();
        end else if (fl) begin
            m_out.instr = NOP;
            m_out.addr  = pc;
            m_out.valid = 1'b0;
        end else if (!st) begin
            m_out.instr = (ld && la == pc) ? ld_d : m_mem[pc];
            m_out.addr  = pc;
            m_out.valid = 1'b1;
            m_cnt       = (m_cnt + 1) % 256;
        end
        m_out.cnt = 8'(m_cnt);
        if (ld) m_mem[la] = ld_d;
        sb_q.push_back(m_out);
        @(negedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [5:0] pc);
        cycle(1'b1, pc, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int drain;
        model_reset();
        @(negedge CLK); #1;

        // Reset state.
        check("reset_instr", 32'(INSTR), 32'(NOP));
        check("reset_valid", 32'(INSTR_VALID), 32'd0);

        // Load the whole program while reset is held.
        for (int a = 0; a < 64; a++)
            cycle(1'b0, 6'd0, 1'b1, 6'(a), 16'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b1, 6'd0, 16'h1111, 1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b1, 6'd1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b1, 6'd2, 16'h3333, 1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b1, 6'd3, 16'h4444, 1'b0, 1'b0);

        // Basic sequential fetch.
        for (int a = 0; a < 4; a++) fetch(6'(a));
        check("seq_instr3", 32'(INSTR), 32'h4444);
        check("seq_cnt4", 32'(FETCH_CNT), 32'd4);

        // Three-cycle stall while INSTR holds 2222 and PC_ADDR keeps moving.
        fetch(6'd1);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 6'(20 + i), 1'b0, 6'd0, 16'h0, 1'b1, 1'b0);
        check("stall_hold", 32'(INSTR), 32'h2222);
        fetch(6'd7);

        // Flush takes priority over stall.
        cycle(1'b1, 6'd5, 1'b0, 6'd0, 16'h0, 1'b1, 1'b1);
        check("flush_addr", 32'(INSTR_ADDR), 32'd5);

        // Write-first collision, then a refetch of the same address.
        cycle(1'b1, 6'd10, 1'b1, 6'd10, 16'hBEEF, 1'b0, 1'b0);
        check("collide", 32'(INSTR), 32'hBEEF);
        fetch(6'd3);
        fetch(6'd10);
        check("refetch", 32'(INSTR), 32'hBEEF);

        // PC wraps from 63 to 0.
        fetch(6'd62); fetch(6'd63); fetch(6'd0);
        check("wrap_instr0", 32'(INSTR), 32'h1111);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] pc;
            logic       ld;
            logic [5:0] la;
            pc = 6'($urandom_range(0, 63));
            ld = ($urandom_range(0, 9) < 3);
            la = ($urandom_range(0, 3) == 0) ? pc : 6'($urandom_range(0, 63));
            cycle(1'b1, pc, ld, la, 16'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        // 300 fetches from reset, so the counter wraps once and ends at 44.
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) fetch(6'($urandom_range(0, 63)));
        check("cnt_300", 32'(FETCH_CNT), 32'd44);

        // Asynchronous reset in the middle of a cycle clears the outputs at once.
        @(posedge CLK); #2;
        RST = 1'b0;
        model_reset();
        #1;
        check("async_instr", 32'(INSTR), 32'(NOP));
        check("async_valid", 32'(INSTR_VALID), 32'd0);
        check("async_addr", 32'(INSTR_ADDR), 32'd0);
        check("async_cnt", 32'(FETCH_CNT), 32'd0);
        @(negedge CLK); #1;
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0);
        // The memory kept its contents through reset.
        fetch(6'd0); fetch(6'd10); fetch(6'd62);

        // Drain the scoreboard within a bounded number of cycles.
        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(negedge CLK); #1;
            drain++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
